// File: rtl/pad_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_hub_pkg
// Description : Shared definitions for the drum-pad sensor hub.
//               - event kind codes
//               - round FSM state encoding
//               - judged-event record and its constructor
// Revision    : 1.0  initial release
// ============================================================================
package pad_hub_pkg;

   // Event kind codes, carried in the top two bits of every FIFO entry
   localparam logic [1:0] KIND_STRAY   = 2'b00;
   localparam logic [1:0] KIND_HIT     = 2'b01;
   localparam logic [1:0] KIND_WRONG   = 2'b10;
   localparam logic [1:0] KIND_TIMEOUT = 2'b11;

   // Event records carry a pad index wide enough for any supported pad count;
   // the hub trims it to its own index width on the way out.
   localparam int EVT_IDX_MAX_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_JUDGE = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0]               kind;
      logic [EVT_IDX_MAX_W-1:0] idx;
   } evt_t;

   function automatic evt_t make_evt(input logic [1:0]               kind,
                                     input logic [EVT_IDX_MAX_W-1:0] idx);
      evt_t e;
      e.kind = kind;
      e.idx  = idx;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pad_debounce
// Description : One sensor channel: 2-flop synchroniser, stability counter
//               and a one-cycle pulse when the debounced level rises.
// Ports       : clock    in  system clock
//               resetn   in  synchronous active-low reset
//               raw_in   in  asynchronous pad level, 1 = pressed
//               rise_out out one-cycle pulse after the debounced level rises
// Revision    : 1.0  initial release
// ============================================================================
module pad_debounce
   import pad_hub_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw_in,
   output logic rise_out
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;                    // any agreement restarts the count
      if (sync2_q != level_q) begin
         // The cycle that would take the count to DEBOUNCE_CYCLES flips the level
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_out = rise_q;

endmodule
`default_nettype wire

// File: rtl/pad_sensor_hub.sv
`default_nettype none
// ============================================================================
// Module      : pad_sensor_hub
// Description : Drum-pad front end: debounced hit detection, lowest-index
//               arbitration, one-target-at-a-time round judging with score,
//               and a show-ahead event FIFO for the processor.
// Ports       : clock, resetn          clock / synchronous active-low reset
//               sensor_in              raw pad levels
//               clear                  sync clear of round, score, FIFO, pend
//               target_valid/idx/ready target offer handshake
//               light_out              one-hot lit pad
//               evt_valid/data, evt_rd FIFO head {kind, idx} and pop
//               score                  saturating correct-hit count
//               hit/mistake/timeout_pulse one-cycle judgement pulses
//               overflow               sticky dropped-event flag
// Revision    : 1.0  initial release
// ============================================================================
module pad_sensor_hub
   import pad_hub_pkg::*;
#(
   parameter int NUM_PADS        = 8,
   parameter int IDX_W           = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 50000000,
   parameter int FIFO_DEPTH      = 8,
   parameter int SCORE_W         = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [NUM_PADS-1:0]   sensor_in,
   input  logic                  clear,
   input  logic                  target_valid,
   input  logic [IDX_W-1:0]      target_idx,
   output logic                  target_ready,
   output logic [NUM_PADS-1:0]   light_out,
   output logic                  evt_valid,
   output logic [IDX_W+1:0]      evt_data,
   input  logic                  evt_rd,
   output logic [SCORE_W-1:0]    score,
   output logic                  hit_pulse,
   output logic                  mistake_pulse,
   output logic                  timeout_pulse,
   output logic                  overflow
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
   localparam logic [NUM_PADS-1:0] PAD_ONE = NUM_PADS'(1);

   // ---------------------------------------------------------------- input path
   logic [NUM_PADS-1:0] rise_vec;

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
      pad_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clock    (clock),
         .resetn   (resetn),
         .raw_in   (sensor_in[g]),
         .rise_out (rise_vec[g])
      );
   end

   // ---------------------------------------------------------------- arbiter
   logic [NUM_PADS-1:0] pend_q, pend_d;
   logic                issue_valid;
   logic [IDX_W-1:0]    issue_idx;
   logic [NUM_PADS-1:0] issue_mask;

   always_comb begin
      issue_valid = 1'b0;
      issue_idx   = '0;
      // Descending scan so the lowest set bit is the last one to win
      for (int i = NUM_PADS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            issue_valid = 1'b1;
            issue_idx   = IDX_W'(i);
         end
      end
      issue_mask = issue_valid ? (PAD_ONE << issue_idx) : '0;
      // A fresh rise on the bit being issued survives: set wins over clear
      pend_d = clear ? '0 : ((pend_q & ~issue_mask) | rise_vec);
   end

   // ---------------------------------------------------------------- round FSM
   state_e              state_q, state_d;
   logic [IDX_W-1:0]    target_q, target_d;
   logic [NUM_PADS-1:0] light_q, light_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic                hit_q, hit_d;
   logic                mistake_q, mistake_d;
   logic                timeout_q, timeout_d;
   logic                ready_q, ready_d;
   logic                push;
   evt_t                push_evt;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      light_d   = light_q;
      timer_d   = timer_q;
      score_d   = score_q;
      hit_d     = 1'b0;
      mistake_d = 1'b0;
      timeout_d = 1'b0;
      push      = 1'b0;
      push_evt  = make_evt(KIND_STRAY, EVT_IDX_MAX_W'(issue_idx));

      case (state_q)
         ST_IDLE: begin
            push = issue_valid;
            if (target_valid && ready_q) begin
               target_d = target_idx;
               light_d  = PAD_ONE << target_idx;
               timer_d  = '0;
               state_d  = ST_ARMED;
            end
         end
         ST_ARMED: begin
            timer_d = timer_q + TMR_W'(1);
            // An issued event takes priority over a timeout in the same cycle
            if (issue_valid) begin
               push    = 1'b1;
               light_d = '0;
               state_d = ST_JUDGE;
               if (issue_idx == target_q) begin
                  push_evt = make_evt(KIND_HIT, EVT_IDX_MAX_W'(issue_idx));
                  hit_d    = 1'b1;
                  if (score_q != '1) begin
                     score_d = score_q + SCORE_W'(1);
                  end
               end else begin
                  push_evt  = make_evt(KIND_WRONG, EVT_IDX_MAX_W'(issue_idx));
                  mistake_d = 1'b1;
               end
            end else if (timer_q == TMR_LAST) begin
               push      = 1'b1;
               push_evt  = make_evt(KIND_TIMEOUT, EVT_IDX_MAX_W'(target_q));
               timeout_d = 1'b1;
               light_d   = '0;
               state_d   = ST_JUDGE;
            end
         end
         ST_JUDGE: begin
            push    = issue_valid;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Clear abandons any round silently
      if (clear) begin
         state_d   = ST_IDLE;
         light_d   = '0;
         score_d   = '0;
         hit_d     = 1'b0;
         mistake_d = 1'b0;
         timeout_d = 1'b0;
         push      = 1'b0;
      end

      // Registered so that ready stays low throughout reset
      ready_d = (state_d == ST_IDLE);
   end

   // ---------------------------------------------------------------- event FIFO
   evt_t              mem_q [FIFO_DEPTH];
   evt_t              mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              pop, full, wr_en;

   always_comb begin
      pop   = evt_rd && (count_q != '0);
      full  = (count_q == FIFO_FULL);
      // When full, a simultaneous pop frees the slot the push lands in
      wr_en = push && (!full || pop);

      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_evt;
      end
      wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d   = pop   ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      count_d    = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + FCNT_W'(1);
      end else if (!wr_en && pop) begin
         count_d = count_q - FCNT_W'(1);
      end
      overflow_d = overflow_q | (push && full && !pop);

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pend_q     <= '0;
         state_q    <= ST_IDLE;
         target_q   <= '0;
         light_q    <= '0;
         timer_q    <= '0;
         score_q    <= '0;
         hit_q      <= 1'b0;
         mistake_q  <= 1'b0;
         timeout_q  <= 1'b0;
         ready_q    <= 1'b0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         state_q    <= state_d;
         target_q   <= target_d;
         light_q    <= light_d;
         timer_q    <= timer_d;
         score_q    <= score_d;
         hit_q      <= hit_d;
         mistake_q  <= mistake_d;
         timeout_q  <= timeout_d;
         ready_q    <= ready_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   evt_t head_evt;
   logic unused_head_idx;

   assign head_evt        = mem_q[rd_ptr_q];
   assign unused_head_idx = ^head_evt.idx;
   assign evt_valid       = (count_q != '0);
   assign evt_data        = evt_valid ? {head_evt.kind, head_evt.idx[IDX_W-1:0]} : '0;
   assign target_ready    = ready_q;
   assign light_out       = light_q;
   assign score           = score_q;
   assign hit_pulse       = hit_q;
   assign mistake_pulse   = mistake_q;
   assign timeout_pulse   = timeout_q;
   assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_sensor_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_sensor_hub
// Description : Directed self-checking bench for pad_sensor_hub with short
//               debounce / timeout windows and a 4-entry FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pad_sensor_hub;

   localparam int NUM_PADS = 8;
   localparam int IDX_W    = 3;

   logic                clock = 1'b0;
   logic                resetn;
   logic [NUM_PADS-1:0] sensor_in;
   logic                clear;
   logic                target_valid;
   logic [IDX_W-1:0]    target_idx;
   logic                target_ready;
   logic [NUM_PADS-1:0] light_out;
   logic                evt_valid;
   logic [IDX_W+1:0]    evt_data;
   logic                evt_rd;
   logic [15:0]         score;
   logic                hit_pulse;
   logic                mistake_pulse;
   logic                timeout_pulse;
   logic                overflow;

   int n_vec = 0;
   int n_bad = 0;

   pad_sensor_hub #(
      .NUM_PADS        (8),
      .IDX_W           (3),
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_CYCLES  (20),
      .FIFO_DEPTH      (4),
      .SCORE_W         (16)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .sensor_in     (sensor_in),
      .clear         (clear),
      .target_valid  (target_valid),
      .target_idx    (target_idx),
      .target_ready  (target_ready),
      .light_out     (light_out),
      .evt_valid     (evt_valid),
      .evt_data      (evt_data),
      .evt_rd        (evt_rd),
      .score         (score),
      .hit_pulse     (hit_pulse),
      .mistake_pulse (mistake_pulse),
      .timeout_pulse (timeout_pulse),
      .overflow      (overflow)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; returns 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   function automatic logic [31:0] pulses();
      return {29'd0, hit_pulse, mistake_pulse, timeout_pulse};
   endfunction

   initial begin
      resetn       = 1'b0;
      sensor_in    = '0;
      clear        = 1'b0;
      target_valid = 1'b0;
      target_idx   = '0;
      evt_rd       = 1'b0;

      // ---------------- reset
      tick(3);
      check_eq("rst_ready",    {31'd0, target_ready}, 32'd0);
      check_eq("rst_light",    {24'd0, light_out},    32'd0);
      check_eq("rst_evtvalid", {31'd0, evt_valid},    32'd0);
      check_eq("rst_score",    {16'd0, score},        32'd0);
      check_eq("rst_pulses",   pulses(),              32'd0);
      check_eq("rst_overflow", {31'd0, overflow},     32'd0);
      resetn = 1'b1;
      tick(1);
      check_eq("ready_after_rst", {31'd0, target_ready}, 32'd1);

      // ---------------- 1: bounce rejected, stable press gives STRAY 3
      sensor_in[3] = 1'b1;
      tick(3);
      sensor_in[3] = 1'b0;
      tick(10);
      check_eq("bounce_no_evt", {31'd0, evt_valid}, 32'd0);
      sensor_in[3] = 1'b1;
      tick(7);
      check_eq("stray3_not_yet", {31'd0, evt_valid}, 32'd0);
      tick(1);
      check_eq("stray3_valid", {31'd0, evt_valid}, 32'd1);
      check_eq("stray3_data",  {27'd0, evt_data},  32'h03);
      sensor_in[3] = 1'b0;
      evt_rd       = 1'b1;
      tick(1);
      evt_rd = 1'b0;
      check_eq("stray3_popped", {31'd0, evt_valid}, 32'd0);
      tick(10);
      check_eq("release_no_evt", {31'd0, evt_valid}, 32'd0);

      // ---------------- 2: target 5, correct hit
      target_valid = 1'b1;
      target_idx   = 3'd5;
      tick(1);
      target_valid = 1'b0;
      check_eq("t5_light",    {24'd0, light_out},    32'h20);
      check_eq("t5_ready_lo", {31'd0, target_ready}, 32'd0);
      sensor_in[5] = 1'b1;
      tick(7);
      check_eq("t5_light_hold", {24'd0, light_out}, 32'h20);
      check_eq("t5_no_pulse",   pulses(),           32'd0);
      tick(1);
      check_eq("t5_hit_pulse", pulses(),              32'd4);
      check_eq("t5_light_off", {24'd0, light_out},    32'd0);
      check_eq("t5_score",     {16'd0, score},        32'd1);
      check_eq("t5_evt",       {27'd0, evt_data},     32'h0D);
      check_eq("t5_judge_rdy", {31'd0, target_ready}, 32'd0);
      sensor_in[5] = 1'b0;
      evt_rd       = 1'b1;
      tick(1);
      evt_rd = 1'b0;
      check_eq("t5_ready_back", {31'd0, target_ready}, 32'd1);
      check_eq("t5_pulse_end",  pulses(),              32'd0);
      check_eq("t5_popped",     {31'd0, evt_valid},    32'd0);
      tick(10);

      // ---------------- 3: target 2, pads 6 and 1 together
      target_valid = 1'b1;
      target_idx   = 3'd2;
      tick(1);
      target_valid = 1'b0;
      check_eq("t2_light", {24'd0, light_out}, 32'h04);
      sensor_in[6] = 1'b1;
      sensor_in[1] = 1'b1;
      tick(8);
      check_eq("t2_mistake", pulses(),           32'd2);
      check_eq("t2_score",   {16'd0, score},     32'd1);
      check_eq("t2_light0",  {24'd0, light_out}, 32'd0);
      check_eq("t2_wrong1",  {27'd0, evt_data},  32'h11);
      tick(1);
      check_eq("t2_mistake_once", pulses(),        32'd0);
      check_eq("t2_head_kept", {27'd0, evt_data}, 32'h11);
      evt_rd = 1'b1;
      tick(1);
      check_eq("t2_stray6",  {27'd0, evt_data},  32'h06);
      check_eq("t2_valid6",  {31'd0, evt_valid}, 32'd1);
      tick(1);
      evt_rd = 1'b0;
      check_eq("t2_empty",   {31'd0, evt_valid}, 32'd0);
      sensor_in[6] = 1'b0;
      sensor_in[1] = 1'b0;
      tick(10);

      // ---------------- 4: target 0, timeout
      target_valid = 1'b1;
      target_idx   = 3'd0;
      tick(1);
      target_valid = 1'b0;
      tick(19);
      check_eq("t0_before_to", pulses(),           32'd0);
      check_eq("t0_lit",       {24'd0, light_out}, 32'h01);
      tick(1);
      check_eq("t0_timeout", pulses(),           32'd1);
      check_eq("t0_light0",  {24'd0, light_out}, 32'd0);
      check_eq("t0_evt",     {27'd0, evt_data},  32'h18);
      check_eq("t0_score",   {16'd0, score},     32'd1);
      evt_rd = 1'b1;
      tick(1);
      evt_rd = 1'b0;
      check_eq("t0_popped", {31'd0, evt_valid}, 32'd0);
      tick(3);

      // ---------------- 5: overflow, push+pop while full, clear
      sensor_in = 8'h1F;
      tick(11);
      check_eq("ov_four_no_ov", {31'd0, overflow}, 32'd0);
      tick(1);
      check_eq("ov_set",   {31'd0, overflow},  32'd1);
      check_eq("ov_valid", {31'd0, evt_valid}, 32'd1);
      check_eq("ov_head0", {27'd0, evt_data},  32'h00);
      sensor_in = 8'h80;
      tick(7);
      evt_rd = 1'b1;
      tick(1);
      check_eq("pp_head1", {27'd0, evt_data}, 32'h01);
      tick(1);
      check_eq("pp_head2", {27'd0, evt_data}, 32'h02);
      tick(1);
      check_eq("pp_head3", {27'd0, evt_data}, 32'h03);
      tick(1);
      evt_rd = 1'b0;
      check_eq("pp_head7",  {27'd0, evt_data},  32'h07);
      check_eq("pp_valid7", {31'd0, evt_valid}, 32'd1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check_eq("clr_valid",    {31'd0, evt_valid}, 32'd0);
      check_eq("clr_overflow", {31'd0, overflow},  32'd0);
      check_eq("clr_score",    {16'd0, score},     32'd0);
      sensor_in = '0;
      tick(10);

      // ---------------- 6: reset mid-round with score 1
      target_valid = 1'b1;
      target_idx   = 3'd4;
      tick(1);
      target_valid = 1'b0;
      sensor_in[4] = 1'b1;
      tick(8);
      check_eq("r6_score1", {16'd0, score}, 32'd1);
      sensor_in[4] = 1'b0;
      evt_rd       = 1'b1;
      tick(1);
      evt_rd = 1'b0;
      tick(10);
      target_valid = 1'b1;
      target_idx   = 3'd4;
      tick(1);
      target_valid = 1'b0;
      check_eq("r6_armed_light", {24'd0, light_out}, 32'h10);
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      check_eq("r6_light0", {24'd0, light_out},    32'd0);
      check_eq("r6_score0", {16'd0, score},        32'd0);
      check_eq("r6_pulses", pulses(),              32'd0);
      check_eq("r6_ready0", {31'd0, target_ready}, 32'd0);
      check_eq("r6_fifo",   {31'd0, evt_valid},    32'd0);
      tick(1);
      check_eq("r6_ready1", {31'd0, target_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
